// File: rtl/asp_net_tx_buffer.sv
// asp_net_tx_buffer: FIFO of tagged packets from the ASP network output,
// driven onto a valid/ready link with ACK wait, timed retransmit and drop.
module asp_net_tx_buffer #(
    parameter int DATA_SIZE  = 32,
    parameter int TAG_SIZE   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16,
    parameter int MAX_RETRY  = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              asp_data_ready_in,
    input  logic [DATA_SIZE+TAG_SIZE-1:0]     asp_data_tag_in,
    output logic                              full_out,
    output logic                              overflow_out,
    output logic [$clog2(FIFO_DEPTH):0]       count_out,
    output logic                              link_valid_out,
    output logic [DATA_SIZE+TAG_SIZE-1:0]     link_data_tag_out,
    input  logic                              link_ready_in,
    input  logic                              link_ack_in,
    output logic                              drop_out
);
    localparam int W     = DATA_SIZE + TAG_SIZE;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [FIFO_DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic             drop_q, drop_d;
    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic             push_ok, pop;

    // Next-state: push acceptance, link FSM (send / ack wait / retry / drop), FIFO bookkeeping
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        state_d    = state_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        drop_d     = 1'b0;
        pop        = 1'b0;
        // Admission is decided on the occupancy at the start of the cycle,
        // so a push while full is lost even if a pop happens in the same cycle.
        push_ok    = asp_data_ready_in && (count_q < CNT_W'(FIFO_DEPTH));
        overflow_d = asp_data_ready_in && !push_ok;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_SEND;
                    retry_d = '0;
                end
            end
            ST_SEND: begin
                // ACK is not looked at here, so an ACK coincident with the transfer is ignored
                if (link_ready_in) begin
                    state_d = ST_WAIT;
                    timer_d = '0;
                end
            end
            ST_WAIT: begin
                // ACK wins over a coincident timeout
                if (link_ack_in) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = ST_SEND;
                    end else begin
                        pop     = 1'b1;
                        drop_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (push_ok) begin
            mem_d[wr_ptr_q] = asp_data_tag_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        full_d  = (count_d == CNT_W'(FIFO_DEPTH));
    end

    // State registers; reset discards all buffered and in-flight packets silently
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= 1'b0;
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            retry_q    <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
        end
    end

    // Output decode; data bus is zeroed whenever nothing is offered
    always_comb begin
        full_out          = full_q;
        overflow_out      = overflow_q;
        count_out         = count_q;
        drop_out          = drop_q;
        link_valid_out    = (state_q == ST_SEND);
        link_data_tag_out = link_valid_out ? mem_q[rd_ptr_q] : '0;
    end
endmodule

// File: tb/tb_asp_net_tx_buffer.sv
// Directed bench for asp_net_tx_buffer (default parameters).
module tb_asp_net_tx_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        asp_data_ready_in;
    logic [39:0] asp_data_tag_in;
    logic        full_out, overflow_out, link_valid_out, link_ready_in, link_ack_in, drop_out;
    logic [2:0]  count_out;
    logic [39:0] link_data_tag_out;

    int n_tests = 0;
    int n_fail  = 0;

    // observation counters, cleared by the stimulus between tests
    int cyc = 0;
    int xfer_cnt = 0, drop_cnt = 0, ovf_cnt = 0;
    int xfer_t [0:7];
    int drop_t = 0;

    asp_net_tx_buffer dut (
        .clk               (clk),
        .reset             (reset),
        .asp_data_ready_in (asp_data_ready_in),
        .asp_data_tag_in   (asp_data_tag_in),
        .full_out          (full_out),
        .overflow_out      (overflow_out),
        .count_out         (count_out),
        .link_valid_out    (link_valid_out),
        .link_data_tag_out (link_data_tag_out),
        .link_ready_in     (link_ready_in),
        .link_ack_in       (link_ack_in),
        .drop_out          (drop_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && link_valid_out && link_ready_in) begin
            if (xfer_cnt < 8) xfer_t[xfer_cnt] = cyc;
            xfer_cnt++;
        end
        if (drop_out) begin
            drop_cnt++;
            drop_t = cyc;
        end
        if (overflow_out) ovf_cnt++;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        xfer_cnt = 0; drop_cnt = 0; ovf_cnt = 0; drop_t = 0;
    endtask

    task automatic push(input logic [39:0] d);
        asp_data_ready_in = 1'b1;
        asp_data_tag_in   = d;
        tick();
        asp_data_ready_in = 1'b0;
        asp_data_tag_in   = '0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!link_valid_out && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 64'(link_valid_out), 64'd1);
    endtask

    task automatic wait_drop(input string tag);
        int n = 0;
        while (drop_cnt == 0 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(drop_cnt), 64'd1);
    endtask

    initial begin
        reset = 1'b0; asp_data_ready_in = 1'b0; asp_data_tag_in = '0;
        link_ready_in = 1'b0; link_ack_in = 1'b0;
        tick(); tick();
        // reset state
        chk("rst_count", 64'(count_out), 64'd0);
        chk("rst_full", 64'(full_out), 64'd0);
        chk("rst_valid", 64'(link_valid_out), 64'd0);
        chk("rst_data", 64'(link_data_tag_out), 64'd0);
        chk("rst_drop_ovf", 64'({drop_out, overflow_out}), 64'd0);
        reset = 1'b1;
        tick();

        // T1: single packet, ACK three cycles after transfer
        clr();
        push(40'h12345678A5);
        chk("t1_count1", 64'(count_out), 64'd1);
        chk("t1_not_yet_valid", 64'(link_valid_out), 64'd0);
        link_ready_in = 1'b1;
        tick();
        chk("t1_valid", 64'(link_valid_out), 64'd1);
        chk("t1_data", 64'(link_data_tag_out), 64'h12345678A5);
        tick();
        link_ready_in = 1'b0;
        chk("t1_valid_1cyc", 64'(link_valid_out), 64'd0);
        chk("t1_data_zero", 64'(link_data_tag_out), 64'd0);
        chk("t1_count_held", 64'(count_out), 64'd1);
        tick(); tick();
        link_ack_in = 1'b1;
        tick();
        link_ack_in = 1'b0;
        chk("t1_count0", 64'(count_out), 64'd0);
        chk("t1_xfers", 64'(xfer_cnt), 64'd1);
        chk("t1_nodrop", 64'(drop_cnt), 64'd0);

        // T2: ready withheld for 5 cycles while valid
        clr();
        push(40'hDEADBEEF3C);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_hold_valid%0d", i), 64'(link_valid_out), 64'd1);
            chk($sformatf("t2_hold_data%0d", i), 64'(link_data_tag_out), 64'hDEADBEEF3C);
            tick();
        end
        link_ready_in = 1'b1;
        chk("t2_valid6", 64'(link_valid_out), 64'd1);
        chk("t2_data6", 64'(link_data_tag_out), 64'hDEADBEEF3C);
        tick();
        link_ready_in = 1'b0;
        chk("t2_valid_low", 64'(link_valid_out), 64'd0);
        chk("t2_xfers", 64'(xfer_cnt), 64'd1);
        link_ack_in = 1'b1;
        tick();
        link_ack_in = 1'b0;
        chk("t2_count0", 64'(count_out), 64'd0);

        // T3: never ACK -> 4 sends 17 cycles apart, then one drop
        clr();
        link_ready_in = 1'b1;
        push(40'h00000000C3);
        wait_drop("t3_drop_seen");
        link_ready_in = 1'b0;
        tick(); tick();
        chk("t3_xfers", 64'(xfer_cnt), 64'd4);
        chk("t3_gap1", 64'(xfer_t[1] - xfer_t[0]), 64'd17);
        chk("t3_gap2", 64'(xfer_t[2] - xfer_t[1]), 64'd17);
        chk("t3_gap3", 64'(xfer_t[3] - xfer_t[2]), 64'd17);
        chk("t3_drop_time", 64'(drop_t - xfer_t[3]), 64'd17);
        chk("t3_drop_once", 64'(drop_cnt), 64'd1);
        chk("t3_count0", 64'(count_out), 64'd0);
        chk("t3_idle", 64'(link_valid_out), 64'd0);

        // T4: five back-to-back pushes into a 4-deep FIFO
        clr();
        asp_data_ready_in = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            asp_data_tag_in = 40'(i);
            tick();
            if (i == 3) chk("t4_not_full3", 64'(full_out), 64'd0);
            if (i == 4) begin
                chk("t4_full4", 64'(full_out), 64'd1);
                chk("t4_count4", 64'(count_out), 64'd4);
                chk("t4_no_ovf_yet", 64'(overflow_out), 64'd0);
            end
        end
        asp_data_ready_in = 1'b0;
        asp_data_tag_in   = '0;
        chk("t4_ovf_pulse", 64'(overflow_out), 64'd1);
        tick();
        chk("t4_ovf_end", 64'(overflow_out), 64'd0);
        chk("t4_count_still4", 64'(count_out), 64'd4);
        for (int k = 1; k <= 4; k++) begin
            wait_valid($sformatf("t4_valid%0d", k));
            chk($sformatf("t4_order%0d", k), 64'(link_data_tag_out), 64'(k));
            link_ready_in = 1'b1;
            tick();
            link_ready_in = 1'b0;
            link_ack_in = 1'b1;
            tick();
            link_ack_in = 1'b0;
        end
        chk("t4_count0", 64'(count_out), 64'd0);
        chk("t4_full_clr", 64'(full_out), 64'd0);
        chk("t4_ovf_once", 64'(ovf_cnt), 64'd1);
        chk("t4_xfers", 64'(xfer_cnt), 64'd4);

        // T5: ACK on the very timeout cycle counts as ACK
        clr();
        link_ready_in = 1'b1;
        push(40'h5555AAAA77);
        tick();
        tick();  // transfer edge
        link_ready_in = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        link_ack_in = 1'b1;
        tick();
        link_ack_in = 1'b0;
        chk("t5_count0", 64'(count_out), 64'd0);
        link_ready_in = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        link_ready_in = 1'b0;
        chk("t5_no_retx", 64'(xfer_cnt), 64'd1);
        chk("t5_nodrop", 64'(drop_cnt), 64'd0);
        chk("t5_idle", 64'(link_valid_out), 64'd0);

        // T6: reset while waiting for ACK with 3 entries buffered
        clr();
        push(40'h0000000011);
        push(40'h0000000022);
        push(40'h0000000033);
        wait_valid("t6_valid");
        link_ready_in = 1'b1;
        tick();
        link_ready_in = 1'b0;
        chk("t6_pre_count3", 64'(count_out), 64'd3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_count0", 64'(count_out), 64'd0);
        chk("t6_outs0", 64'({full_out, overflow_out, link_valid_out, drop_out}), 64'd0);
        chk("t6_data0", 64'(link_data_tag_out), 64'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("t6_stays_idle", 64'(link_valid_out), 64'd0);
        chk("t6_no_drop", 64'(drop_cnt), 64'd0);
        push(40'hCAFEF00D99);
        chk("t6_post_count1", 64'(count_out), 64'd1);
        wait_valid("t6_post_valid");
        chk("t6_post_data", 64'(link_data_tag_out), 64'hCAFEF00D99);
        link_ready_in = 1'b1;
        tick();
        link_ready_in = 1'b0;
        link_ack_in = 1'b1;
        tick();
        link_ack_in = 1'b0;
        chk("t6_post_count0", 64'(count_out), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
